// File: rtl/packet_pb_scheduler_if.sv
// Bundle between the per-TG descriptor logic, the packet playback scheduler and the shared packet memory.
interface packet_pb_scheduler_if #(
  parameter int unsigned N          = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
);
  logic                      enable;
  logic [N-1:0]              ready;
  logic [N-1:0]              request;
  logic [N*ADDR_WIDTH-1:0]   pkt_addr;
  logic [N*LEN_WIDTH-1:0]    pkt_len;
  logic                      mem_rd_en;
  logic [ADDR_WIDTH-1:0]     mem_rd_addr;
  logic [N-1:0]              grant;
  logic [N-1:0]              flit_valid;
  logic [N-1:0]              done;
  logic                      busy;

  // Descriptor/requester side drives the requests and observes the playback stream.
  modport master (
    output enable, ready, request, pkt_addr, pkt_len,
    input  mem_rd_en, mem_rd_addr, grant, flit_valid, done, busy
  );

  // Scheduler side.
  modport slave (
    input  enable, ready, request, pkt_addr, pkt_len,
    output mem_rd_en, mem_rd_addr, grant, flit_valid, done, busy
  );
endinterface

// File: rtl/packet_pb_scheduler.sv
// Round-robin playback scheduler: grants one TG at a time the shared single-read-port
// packet memory and streams its packet flit by flit (memory read latency of one cycle).
module packet_pb_scheduler #(
  parameter int unsigned N          = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  packet_pb_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE0 = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          prio_q, prio_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rd_en_q, rd_en_d;
  logic [N-1:0]          fv_q, fv_d;
  logic [N-1:0]          done_q, done_d;
  logic                  busy_q, busy_d;

  logic [N-1:0]          eligible;
  logic [IDX_W-1:0]      prio_idx;
  logic [PW-1:0]         pos;
  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  logic [N-1:0]          win_onehot;
  logic [N-1:0]          prio_next;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;

  // Round-robin search: first eligible TG at or above the priority pointer, wrapping.
  always_comb begin
    eligible = bus.enable ? (bus.ready & bus.request) : '0;
    prio_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (prio_q[i]) prio_idx = IDX_W'(i);
    end
    found   = 1'b0;
    win_idx = '0;
    pos     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, prio_idx} + PW'(i);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && eligible[pos[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = pos[IDX_W-1:0];
      end
    end
    win_onehot = found ? (N'(1) << win_idx) : '0;
    prio_next  = (win_idx == IDX_W'(N - 1)) ? N'(1) : (N'(1) << (win_idx + IDX_W'(1)));
  end

  // Descriptor mux for the winning TG.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IDX_W'(i) == win_idx) begin
        sel_addr = bus.pkt_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = bus.pkt_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; every output is the registered copy of these values.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    fv_d    = '0;
    done_d  = '0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          prio_d  = prio_next;
          grant_d = win_onehot;
          len_d   = sel_len;
          busy_d  = 1'b1;
          if (sel_len != '0) begin
            state_d = READ;
            rd_en_d = 1'b1;
            addr_d  = sel_addr;
            cnt_d   = LEN_WIDTH'(1);
          end else begin
            state_d = DONE0;
            done_d  = win_onehot;
          end
        end
      end
      READ: begin
        busy_d = 1'b1;
        fv_d   = grant_q;
        if (cnt_q == len_q) begin
          state_d = DRAIN;
          done_d  = grant_q;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = cnt_q + LEN_WIDTH'(1);
        end
      end
      DRAIN, DONE0: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= N'(1);
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      fv_q    <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.grant       = grant_q;
  assign bus.flit_valid  = fv_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_packet_pb_scheduler.sv
// Bench for packet_pb_scheduler: directed scenarios plus random traffic against a
// transaction-level model that plans each packet's per-cycle outputs when it is granted.
module tb_packet_pb_scheduler;

  localparam int unsigned N    = 4;
  localparam int unsigned AW   = 8;
  localparam int unsigned LW   = 4;
  localparam int          MAXC = 4000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  packet_pb_scheduler_if #(.N(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  packet_pb_scheduler #(.N(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0]  grant;
    logic [N-1:0]  fv;
    logic [N-1:0]  done;
    logic          rd_en;
    logic          busy;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q [MAXC];
  int            cyc;
  int            busy_until;
  int            prio_idx;
  int            n_tests;
  int            n_fail;
  logic [AW-1:0] addr_a [N];
  logic [LW-1:0] len_a  [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic void clear_future(input int from);
    for (int c = from; c < MAXC; c++) exp_q[c] = '{default: '0};
  endfunction

  function automatic void set_pkt(input int i, input int a, input int l);
    addr_a[i] = AW'(a);
    len_a[i]  = LW'(l);
  endfunction

  // Reference: at an arbitration point, lay out the whole packet's outputs over future cycles.
  task automatic model(input logic rst, input logic en, input logic [N-1:0] rdy, input logic [N-1:0] req);
    logic [N-1:0]  elig;
    int            w;
    int            len;
    logic [AW-1:0] a;
    logic [N-1:0]  oh;
    if (rst) begin
      clear_future(cyc + 1);
      busy_until = cyc;
      prio_idx   = 0;
      return;
    end
    elig = en ? (rdy & req) : '0;
    if (cyc > busy_until && elig != '0) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (prio_idx + i) % N;
        if (w < 0 && ((elig >> j) & N'(1)) != '0) w = j;
      end
      len      = int'(len_a[w]);
      a        = addr_a[w];
      oh       = N'(1) << w;
      prio_idx = (w + 1) % N;
      if (len == 0) begin
        exp_q[cyc+1].grant = oh;
        exp_q[cyc+1].done  = oh;
        exp_q[cyc+1].busy  = 1'b1;
        busy_until = cyc + 1;
      end else begin
        for (int k = 1; k <= len; k++) begin
          exp_q[cyc+k].grant = oh;
          exp_q[cyc+k].rd_en = 1'b1;
          exp_q[cyc+k].addr  = AW'(int'(a) + k - 1);
          exp_q[cyc+k].busy  = 1'b1;
          if (k >= 2) exp_q[cyc+k].fv = oh;
        end
        exp_q[cyc+len+1].grant = oh;
        exp_q[cyc+len+1].fv    = oh;
        exp_q[cyc+len+1].done  = oh;
        exp_q[cyc+len+1].busy  = 1'b1;
        busy_until = cyc + len + 1;
      end
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive this cycle's inputs, update the model.
  task automatic step(input logic rst, input logic en, input logic [N-1:0] rdy, input logic [N-1:0] req);
    exp_t e;
    @(negedge clock);
    if (cyc >= 1) begin
      e = exp_q[cyc];
      check_eq("grant",      32'(bus.grant),      32'(e.grant));
      check_eq("mem_rd_en",  32'(bus.mem_rd_en),  32'(e.rd_en));
      check_eq("flit_valid", 32'(bus.flit_valid), 32'(e.fv));
      check_eq("done",       32'(bus.done),       32'(e.done));
      check_eq("busy",       32'(bus.busy),       32'(e.busy));
      if (e.rd_en) check_eq("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(e.addr));
    end
    reset       = rst;
    bus.enable  = en;
    bus.ready   = rdy;
    bus.request = req;
    for (int i = 0; i < N; i++) begin
      bus.pkt_addr[i*AW +: AW] = addr_a[i];
      bus.pkt_len[i*LW +: LW]  = len_a[i];
    end
    model(rst, en, rdy, req);
    @(posedge clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    busy_until = -1;
    prio_idx   = 0;
    clear_future(0);
    for (int i = 0; i < N; i++) set_pkt(i, 0, 0);
    bus.enable   = 1'b0;
    bus.ready    = '0;
    bus.request  = '0;
    bus.pkt_addr = '0;
    bus.pkt_len  = '0;

    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);

    // Single TG0 packet of 3 flits from 0x10.
    set_pkt(0, 'h10, 3);
    step(1'b0, 1'b1, 4'b0001, 4'b0001);
    idle(6);

    // Everyone eligible with 2-flit packets: strict rotation.
    for (int i = 0; i < N; i++) set_pkt(i, 'h20 + 16 * i, 2);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'b1111, 4'b1111);
    idle(5);

    // Address wrap past 0xFF.
    set_pkt(1, 'hFE, 4);
    step(1'b0, 1'b1, 4'b0010, 4'b0010);
    idle(7);

    // Zero-length packet on TG2, then all eligible: TG3 should follow.
    set_pkt(2, 'h30, 0);
    for (int i = 0; i < N; i++) if (i != 2) set_pkt(i, 'h60 + i, 1);
    step(1'b0, 1'b1, 4'b0100, 4'b0100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b1111, 4'b1111);
    idle(5);

    // Enable dropped mid-transfer: packet completes, nothing new granted.
    set_pkt(0, 'h40, 5);
    step(1'b0, 1'b1, 4'b0001, 4'b0001);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b1111, 4'b1111);
    idle(3);

    // Reset in the middle of a 6-flit transfer; TG0 wins first afterwards.
    set_pkt(0, 'h50, 6);
    step(1'b0, 1'b1, 4'b0001, 4'b0001);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 4'b1111, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b1111, 4'b1111);
    idle(10);

    // Random traffic with occasional reset and enable drops.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (($urandom % 4) == 0) set_pkt(i, 252 + int'($urandom % 4), int'($urandom % 16));
        else                     set_pkt(i, int'($urandom % 256), int'($urandom % 16));
      end
      step(($urandom % 300) == 0, ($urandom % 8) != 0,
           N'($urandom), N'($urandom));
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
